// File: rtl/wall_row_buffer_if.sv
// Tracer-to-buffer push channel: valid/ready handshake carrying one traced
// row result, plus the row index the tracer should compute next.
interface wall_row_buffer_if #(
  parameter int SIZE_W = 11
);
  logic              in_valid;
  logic              in_ready;
  logic [SIZE_W-1:0] in_size;
  logic              in_side;
  logic [9:0]        next_row;

  modport master (output in_valid, in_size, in_side, input in_ready, next_row);
  modport slave  (input in_valid, in_size, in_side, output in_ready, next_row);
endinterface

// File: rtl/wall_row_buffer.sv
// Double-buffered per-row wall trace store: a stage slot filled by the tracer
// and an active slot swapped in at each line start and held for the whole line.
module wall_row_buffer #(
  parameter int ROWS   = 480,
  parameter int SIZE_W = 11
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                frame_start,
  input  logic                line_start,
  wall_row_buffer_if.slave    push,
  output logic [SIZE_W-1:0]   size,
  output logic                side,
  output logic                active_valid,
  output logic                underrun,
  output logic [7:0]          underrun_count,
  input  logic                clear_underrun
);
  localparam int CW = $clog2(ROWS + 1);

  typedef struct packed {
    logic              side;
    logic [SIZE_W-1:0] size;
  } row_t;

  row_t          stg_q, stg_d, act_q, act_d, in_row;
  logic          stg_valid_q, stg_valid_d;
  logic          active_valid_q, active_valid_d;
  logic [CW-1:0] push_left_q, push_left_d;
  logic [CW-1:0] lines_left_q, lines_left_d;
  logic [9:0]    next_row_q, next_row_d;
  logic          underrun_q, underrun_d;
  logic [7:0]    underrun_count_q, underrun_count_d;
  logic          accept, ur_event;

  assign in_row        = '{side: push.in_side, size: push.in_size};
  assign push.in_ready = ~stg_valid_q & (push_left_q != '0);
  assign push.next_row = next_row_q;
  // A push coinciding with frame_start belongs to the old frame and is dropped.
  assign accept        = push.in_valid & push.in_ready & ~frame_start;

  assign size           = act_q.size;
  assign side           = act_q.side;
  assign active_valid   = active_valid_q;
  assign underrun       = underrun_q;
  assign underrun_count = underrun_count_q;

  always_comb begin
    stg_d            = stg_q;
    stg_valid_d      = stg_valid_q;
    act_d            = act_q;
    active_valid_d   = active_valid_q;
    push_left_d      = push_left_q;
    lines_left_d     = lines_left_q;
    next_row_d       = next_row_q;
    underrun_d       = underrun_q;
    underrun_count_d = underrun_count_q;
    ur_event         = 1'b0;

    if (frame_start) begin
      stg_valid_d    = 1'b0;
      active_valid_d = 1'b0;
      push_left_d    = CW'(ROWS);
      lines_left_d   = CW'(ROWS);
      next_row_d     = '0;
    end else begin
      if (accept) begin
        stg_d       = in_row;
        stg_valid_d = 1'b1;
        push_left_d = push_left_q - CW'(1);
        // Last push of the frame leaves next_row parked on ROWS-1.
        if (push_left_q != CW'(1)) next_row_d = next_row_q + 10'd1;
      end
      if (line_start) begin
        active_valid_d = 1'b0;
        if (lines_left_q != '0) begin
          lines_left_d = lines_left_q - CW'(1);
          if (stg_valid_q) begin
            act_d          = stg_q;
            active_valid_d = 1'b1;
            stg_valid_d    = 1'b0;
          end else if (accept) begin
            act_d          = in_row;
            active_valid_d = 1'b1;
            stg_valid_d    = 1'b0;
          end else begin
            ur_event = 1'b1;
          end
        end
      end
    end

    if (clear_underrun) begin
      underrun_d       = 1'b0;
      underrun_count_d = '0;
    end
    if (ur_event) begin
      underrun_d = 1'b1;
      if (underrun_count_d != 8'hFF) underrun_count_d = underrun_count_d + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stg_q            <= '0;
      stg_valid_q      <= 1'b0;
      act_q            <= '0;
      active_valid_q   <= 1'b0;
      push_left_q      <= '0;
      lines_left_q     <= '0;
      next_row_q       <= '0;
      underrun_q       <= 1'b0;
      underrun_count_q <= '0;
    end else begin
      stg_q            <= stg_d;
      stg_valid_q      <= stg_valid_d;
      act_q            <= act_d;
      active_valid_q   <= active_valid_d;
      push_left_q      <= push_left_d;
      lines_left_q     <= lines_left_d;
      next_row_q       <= next_row_d;
      underrun_q       <= underrun_d;
      underrun_count_q <= underrun_count_d;
    end
  end
endmodule

// File: tb/tb_wall_row_buffer.sv
// Directed bench: a ROWS=4 instance for frame/handshake scenarios and a
// ROWS=480 instance for underrun saturation.
module tb_wall_row_buffer;
  logic clk = 1'b0;
  logic rst_n;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  logic        a_fs, a_ls, a_clr, a_side, a_av, a_ur;
  logic [10:0] a_size;
  logic [7:0]  a_urc;
  logic        b_fs, b_ls, b_clr, b_side, b_av, b_ur;
  logic [10:0] b_size;
  logic [7:0]  b_urc;

  wall_row_buffer_if #(.SIZE_W(11)) a_if ();
  wall_row_buffer_if #(.SIZE_W(11)) b_if ();

  wall_row_buffer #(.ROWS(4), .SIZE_W(11)) dut_a (
    .clk(clk), .reset_n(rst_n), .frame_start(a_fs), .line_start(a_ls),
    .push(a_if), .size(a_size), .side(a_side), .active_valid(a_av),
    .underrun(a_ur), .underrun_count(a_urc), .clear_underrun(a_clr));

  wall_row_buffer #(.ROWS(480), .SIZE_W(11)) dut_b (
    .clk(clk), .reset_n(rst_n), .frame_start(b_fs), .line_start(b_ls),
    .push(b_if), .size(b_size), .side(b_side), .active_valid(b_av),
    .underrun(b_ur), .underrun_count(b_urc), .clear_underrun(b_clr));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int acc = 0;
    rst_n = 1'b0;
    #12;
    vecs++;
    if ({a_size, a_side, a_av, a_ur, a_urc, a_if.in_ready, a_if.next_row} !== '0) begin
      errs++; $display("FAIL reset_a: size %0d side %b av %b ur %b cnt %0d rdy %b row %0d, want all 0",
                       a_size, a_side, a_av, a_ur, a_urc, a_if.in_ready, a_if.next_row);
    end
    vecs++;
    if ({b_size, b_side, b_av, b_ur, b_urc, b_if.in_ready, b_if.next_row} !== '0) begin
      errs++; $display("FAIL reset_b: size %0d av %b ur %b cnt %0d rdy %b, want all 0",
                       b_size, b_av, b_ur, b_urc, b_if.in_ready);
    end
    tick();
    rst_n = 1'b1;
    a_if.in_valid = 1'b1; a_if.in_size = 11'd5;
    for (int i = 0; i < 100; i++) begin
      if (a_if.in_ready === 1'b1) acc++;
      tick();
    end
    a_if.in_valid = 1'b0;
    vecs++;
    if (acc !== 0 || a_if.next_row !== 10'd0) begin
      errs++; $display("FAIL idle_no_accept: accepts %0d row %0d, want 0 and 0", acc, a_if.next_row);
    end
  endtask

  task automatic test_nominal();
    a_fs = 1'b1; tick(); a_fs = 1'b0;
    for (int r = 0; r < 4; r++) begin
      a_if.in_valid = 1'b1; a_if.in_size = 11'((r + 1) * 10); a_if.in_side = r[0];
      vecs++;
      if (a_if.next_row !== 10'(r) || a_if.in_ready !== 1'b1) begin
        errs++; $display("FAIL nominal_next_row r%0d: row %0d rdy %b, want row %0d rdy 1",
                         r, a_if.next_row, a_if.in_ready, r);
      end
      tick();
      a_if.in_valid = 1'b0;
      a_ls = 1'b1; tick(); a_ls = 1'b0;
      vecs++;
      if (a_size !== 11'((r + 1) * 10) || a_side !== r[0] || a_av !== 1'b1) begin
        errs++; $display("FAIL nominal_line%0d: size %0d side %b av %b, want size %0d side %b av 1",
                         r + 1, a_size, a_side, a_av, (r + 1) * 10, r[0]);
      end
    end
    for (int l = 5; l <= 6; l++) begin
      a_ls = 1'b1; tick(); a_ls = 1'b0;
      vecs++;
      if (a_av !== 1'b0 || a_size !== 11'd40 || a_ur !== 1'b0 || a_urc !== 8'd0) begin
        errs++; $display("FAIL vblank_line%0d: av %b size %0d ur %b cnt %0d, want av 0 size 40 ur 0 cnt 0",
                         l, a_av, a_size, a_ur, a_urc);
      end
    end
    vecs++;
    if (a_if.next_row !== 10'd3) begin
      errs++; $display("FAIL next_row_hold: got %0d want 3", a_if.next_row);
    end
  endtask

  task automatic test_back_to_back();
    int early = 0;
    a_fs = 1'b1; tick(); a_fs = 1'b0;
    a_if.in_valid = 1'b1; a_if.in_size = 11'd1; a_if.in_side = 1'b0;
    tick();
    a_if.in_size = 11'd99; a_if.in_side = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (a_if.in_ready !== 1'b0) early++;
      tick();
    end
    vecs++;
    if (early !== 0 || a_if.in_ready !== 1'b0) begin
      errs++; $display("FAIL backpressure_ready: high on %0d cycles, want 0", early);
    end
    a_ls = 1'b1; tick(); a_ls = 1'b0;
    vecs++;
    if (a_if.in_ready !== 1'b1 || a_size !== 11'd1 || a_av !== 1'b1) begin
      errs++; $display("FAIL swap_then_ready: rdy %b size %0d av %b, want rdy 1 size 1 av 1",
                       a_if.in_ready, a_size, a_av);
    end
    tick();
    a_if.in_valid = 1'b0;
    vecs++;
    if (a_if.in_ready !== 1'b0 || a_if.next_row !== 10'd2) begin
      errs++; $display("FAIL accept_99: rdy %b row %0d, want rdy 0 row 2", a_if.in_ready, a_if.next_row);
    end
    a_ls = 1'b1; tick(); a_ls = 1'b0;
    vecs++;
    if (a_size !== 11'd99 || a_side !== 1'b1 || a_av !== 1'b1) begin
      errs++; $display("FAIL line_99: size %0d side %b av %b, want 99 1 1", a_size, a_side, a_av);
    end
  endtask

  task automatic test_bypass_underrun();
    a_if.in_valid = 1'b1; a_if.in_size = 11'd55; a_if.in_side = 1'b0;
    a_ls = 1'b1; tick(); a_ls = 1'b0; a_if.in_valid = 1'b0;
    vecs++;
    if (a_size !== 11'd55 || a_av !== 1'b1 || a_ur !== 1'b0 || a_if.in_ready !== 1'b1) begin
      errs++; $display("FAIL bypass: size %0d av %b ur %b rdy %b, want 55 1 0 1",
                       a_size, a_av, a_ur, a_if.in_ready);
    end
    a_ls = 1'b1; tick(); a_ls = 1'b0;
    vecs++;
    if (a_size !== 11'd55 || a_av !== 1'b0 || a_ur !== 1'b1 || a_urc !== 8'd1) begin
      errs++; $display("FAIL underrun: size %0d av %b ur %b cnt %0d, want 55 0 1 1",
                       a_size, a_av, a_ur, a_urc);
    end
  endtask

  task automatic test_saturation();
    b_fs = 1'b1; tick(); b_fs = 1'b0;
    for (int i = 0; i < 300; i++) begin
      b_ls = 1'b1; tick(); b_ls = 1'b0; tick();
    end
    vecs++;
    if (b_urc !== 8'd255 || b_ur !== 1'b1) begin
      errs++; $display("FAIL saturate: cnt %0d ur %b, want 255 1", b_urc, b_ur);
    end
    b_clr = 1'b1; tick(); b_clr = 1'b0;
    vecs++;
    if (b_urc !== 8'd0 || b_ur !== 1'b0) begin
      errs++; $display("FAIL clear: cnt %0d ur %b, want 0 0", b_urc, b_ur);
    end
    b_clr = 1'b1; b_ls = 1'b1; tick(); b_clr = 1'b0; b_ls = 1'b0;
    vecs++;
    if (b_urc !== 8'd1 || b_ur !== 1'b1) begin
      errs++; $display("FAIL clear_with_underrun: cnt %0d ur %b, want 1 1", b_urc, b_ur);
    end
  endtask

  task automatic test_priority_reset();
    a_fs = 1'b1; tick(); a_fs = 1'b0;
    a_if.in_valid = 1'b1; a_if.in_size = 11'd7; tick();
    a_if.in_valid = 1'b0;
    a_ls = 1'b1; tick(); a_ls = 1'b0;
    a_if.in_valid = 1'b1; a_if.in_size = 11'd8; tick();
    a_if.in_valid = 1'b0;
    a_fs = 1'b1; a_ls = 1'b1; tick(); a_fs = 1'b0; a_ls = 1'b0;
    vecs++;
    if (a_av !== 1'b0 || a_if.next_row !== 10'd0 || a_if.in_ready !== 1'b1 || a_size !== 11'd7) begin
      errs++; $display("FAIL priority: av %b row %0d rdy %b size %0d, want 0 0 1 7",
                       a_av, a_if.next_row, a_if.in_ready, a_size);
    end
    a_ls = 1'b1; tick(); a_ls = 1'b0;
    vecs++;
    if (a_av !== 1'b0 || a_urc !== 8'd2) begin
      errs++; $display("FAIL stage_flushed: av %b cnt %0d, want 0 2", a_av, a_urc);
    end
    a_if.in_valid = 1'b1; a_if.in_size = 11'd9; tick();
    a_ls = 1'b1; tick(); a_ls = 1'b0; a_if.in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({a_size, a_side, a_av, a_ur, a_urc, a_if.in_ready, a_if.next_row} !== '0) begin
      errs++; $display("FAIL async_reset: size %0d av %b ur %b cnt %0d rdy %b row %0d, want all 0",
                       a_size, a_av, a_ur, a_urc, a_if.in_ready, a_if.next_row);
    end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    {a_fs, a_ls, a_clr, b_fs, b_ls, b_clr} = '0;
    a_if.in_valid = 1'b0; a_if.in_size = '0; a_if.in_side = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_size = '0; b_if.in_side = 1'b0;
    test_reset();
    test_nominal();
    test_back_to_back();
    test_bypass_underrun();
    test_saturation();
    test_priority_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/wall_row_buffer.md
# wall_row_buffer

Double-buffered per-row wall-trace store between the ray tracer and `row_render`. The tracer pushes one `{side, size}` result per screen row over a valid/ready handshake, one row ahead of the beam. On each line start the buffer swaps that result onto registered outputs, which drive `row_render`'s `size`/`side` inputs, and holds them stable for the whole line. It paces the tracer per frame and flags rows the tracer failed to deliver in time.

## Interface
Parameters:
- `ROWS`, 480, visible rows per frame; also the number of pushes accepted per frame.
- `SIZE_W`, 11, width of the wall size field.

Ports:
- `clk`  in  1  pixel clock; the block has one clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `frame_start`  in  1  one-cycle pulse, asserted during the line immediately before visible row 0.
- `line_start`  in  1  one-cycle pulse at the start of every line (hpos==0).
- `in_valid`  in  1  tracer result valid.
- `in_ready`  out  1  buffer can accept a result this cycle.
- `in_size`  in  SIZE_W  traced wall height.
- `in_side`  in  1  wall side (shading select).
- `next_row`  out  10  row index the tracer must compute next.
- `size`  out  SIZE_W  active-row wall size, to `row_render`.
- `side`  out  1  active-row side, to `row_render`.
- `active_valid`  out  1  `size`/`side` are valid for the current line; gates wall enable.
- `underrun`  out  1  sticky: a visible line started with no result staged.
- `underrun_count`  out  8  saturating count of underrun lines.
- `clear_underrun`  in  1  synchronous clear of `underrun` and `underrun_count`.

## Operation
- State is a stage register (`stg_valid`, `stg_size`, `stg_side`) and an active register (`size`, `side`, `active_valid`), plus two counters:
  - `push_left` counts pushes still allowed this frame, 0..ROWS.
  - `lines_left` counts visible lines still to be displayed, 0..ROWS.
- `in_ready = ~stg_valid & (push_left != 0)`. The signal is combinational from registers only and never depends on `in_valid`.
- Accept occurs when `in_valid & in_ready`. On accept:
  - the stage register loads the data;
  - `push_left` decrements;
  - `next_row` increments.
- `next_row` equals ROWS − `push_left` while `push_left` is nonzero, and holds at ROWS−1 once `push_left` reaches 0.
- `frame_start` has priority over everything else. It:
  - flushes the stage register;
  - clears `active_valid`;
  - loads `push_left` and `lines_left` with ROWS;
  - sets `next_row` to 0;
  - ignores any simultaneous `line_start`, and drops any simultaneous push.
- On `line_start` with `lines_left != 0`, `lines_left` decrements and one of three cases applies:
  - Stage full: active loads from the stage register, `active_valid` goes to 1, and the stage empties. An accept in the same cycle is impossible, because `in_ready` is 0 while the stage is full.
  - Stage empty and an accept in the same cycle (bypass): active loads directly from `in_size`/`in_side` and `active_valid` goes to 1. The stage stays empty and this is not an underrun.
  - Stage empty and no accept: `active_valid` goes to 0 and `size`/`side` keep their old values. `underrun` is set to 1 and `underrun_count` increments, saturating at 255.
- On `line_start` with `lines_left == 0` (vblank): `active_valid` goes to 0, there is no swap, and no underrun is counted.
- `clear_underrun` clears `underrun` and `underrun_count`. If an underrun occurs in the same cycle, the result is `underrun` = 1 and `underrun_count` = 1.
- Reset values, all taken asynchronously on `reset_n` low:
  - `size` = 0, `side` = 0, `active_valid` = 0;
  - stage empty, `push_left` = 0, `lines_left` = 0, `next_row` = 0;
  - `underrun` = 0, `underrun_count` = 0;
  - consequently `in_ready` = 0.
- No pushes are accepted after reset until the first `frame_start`.
- A reset mid-frame discards all state. Operation resumes at the next `frame_start`.

## Timing
- `size`, `side` and `active_valid` are registered. They change on the clock edge that samples `line_start` and are stable for the rest of the line. From `line_start` high to output updated is 1 cycle.
- A push is accepted on the rising edge where `in_valid & in_ready`. The stage register is full on the next cycle and `in_ready` drops in that same cycle.
- The tracer may hold `in_valid` high indefinitely. Data must stay stable until it is accepted.
- Throughput is at most one push per line, paced by the swap.
- `underrun` and `underrun_count` update 1 cycle after the offending `line_start`.

## Test plan
- Reset and idle: hold `reset_n` low, then release it.
  - Required: all outputs 0 and `in_ready` 0.
  - Required: `in_valid` held at 1 for 100 cycles produces no accept.
- Nominal frame with ROWS=4: pulse `frame_start`, then push sizes 10, 20, 30, 40, each before its line; issue 6 `line_start` pulses.
  - Required: `size` reads 10, 20, 30, 40 with `active_valid` = 1 on lines 1–4.
  - Required: `active_valid` = 0 on lines 5–6.
  - Required: `next_row` reads 0, 1, 2, 3; `underrun` stays 0.
- Backpressure: push row 0, then keep `in_valid` high with size 99.
  - Required: `in_ready` stays 0 until the next `line_start`.
  - Required: 99 is accepted on the cycle after the swap.
- Bypass and underrun: stage empty, `line_start` coincident with a push of 55 → `size` = 55 and `active_valid` = 1 next cycle, `underrun` = 0.
  - Next `line_start` with no push → `active_valid` = 0, `size` stays 55, `underrun` = 1, `underrun_count` = 1.
- Saturation and clear: force 300 underrun lines (ROWS=480).
  - Required: `underrun_count` = 255.
  - Required: after `clear_underrun`, `underrun_count` = 0 and `underrun` = 0.
- Priority and reset: `frame_start` coincident with `line_start` while the stage is full.
  - Required: stage flushed, `active_valid` = 0, `next_row` = 0.
  - Asserting `reset_n` low mid-line → outputs 0 immediately, with no clock edge needed.
